// File: rtl/proj_seq.sv
// rtl/proj_seq.sv - projection sequencer: walks rows, columns and k-terms of one Q/K/V/O matrix job per start.
// One dot product per output: clear, stream D_MODEL operand pairs, wait out the MAC pipeline, write.
module proj_seq #(
  parameter int SEQ_LEN = 16,
  parameter int D_MODEL = 64,
  parameter int MAC_LAT = 3,
  parameter int ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              proj_start,
  output logic              proj_done,
  output logic [1:0]        job_sel,
  output logic              act_sel,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              mac_clear,
  output logic              mac_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int R_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int C_W = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;
  localparam int L_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [R_W-1:0] R_LAST = R_W'(SEQ_LEN - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(D_MODEL - 1);
  localparam logic [L_W-1:0] L_LAST = L_W'(MAC_LAT - 1);

  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(D_MODEL);
  localparam logic [ADDR_W-1:0] W_STRIDE   = ADDR_W'(D_MODEL * D_MODEL);
  localparam logic [ADDR_W-1:0] O_STRIDE   = ADDR_W'(SEQ_LEN * D_MODEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [R_W-1:0] r_q, r_d;
  logic [C_W-1:0] c_q, c_d;
  logic [C_W-1:0] k_q, k_d;
  logic [L_W-1:0] lat_q, lat_d;
  logic [1:0]     job_q, job_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      lat_q   <= '0;
      job_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      lat_q   <= lat_d;
      job_q   <= job_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    lat_d   = lat_q;
    job_d   = job_q;
    case (state_q)
      S_IDLE: begin
        if (proj_start) begin
          state_d = S_CLR;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
        end
      end
      S_CLR: state_d = S_READ;
      S_READ: begin
        if (rd_ready) begin
          if (k_q == C_LAST) begin
            state_d = S_DRAIN;
            lat_d   = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (lat_q == L_LAST) begin
          state_d = S_WRITE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          k_d     = '0;
          state_d = S_CLR;
          if (c_q == C_LAST) begin
            c_d = '0;
            if (r_q == R_LAST) begin
              r_d     = '0;
              state_d = S_DONE;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        job_d   = job_q + 2'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Addresses follow the counters directly, so they hold for free while a handshake stalls.
  always_comb begin
    proj_done = 1'b0;
    rd_valid  = 1'b0;
    wr_valid  = 1'b0;
    mac_clear = 1'b0;
    mac_last  = 1'b0;
    job_sel   = job_q;
    act_sel   = (job_q == 2'd3);
    act_addr  = ADDR_W'(r_q) * ROW_STRIDE + ADDR_W'(k_q);
    w_addr    = ADDR_W'(job_q) * W_STRIDE + ADDR_W'(k_q) * ROW_STRIDE + ADDR_W'(c_q);
    wr_addr   = ADDR_W'(job_q) * O_STRIDE + ADDR_W'(r_q) * ROW_STRIDE + ADDR_W'(c_q);
    case (state_q)
      S_CLR:   mac_clear = 1'b1;
      S_READ: begin
        rd_valid = 1'b1;
        mac_last = (k_q == C_LAST);
      end
      S_WRITE: wr_valid  = 1'b1;
      S_DONE:  proj_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/proj_seq.md
PROJ_SEQ -- requirements
Module: proj_seq

Interface
REQ-001 Parameter SEQ_LEN, default 16: number of token rows per projection job.
REQ-002 Parameter D_MODEL, default 64: number of input and output features per row.
REQ-003 Parameter MAC_LAT, default 3: datapath cycles from the last operand read to a valid result.
REQ-004 Parameter ADDR_W, default 14: width of all address outputs.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 proj_start  in  1  level request from the block controller; high while a projection stage is active.
REQ-008 proj_done  out  1  one-cycle pulse marking the end of the current job.
REQ-009 job_sel  out  2  current matrix select: 0=Q, 1=K, 2=V, 3=O.
REQ-010 act_sel  out  1  activation source select: 0=LN output buffer, 1=attention output buffer; equals (job_sel==3).
REQ-011 rd_valid  out  1  operand read request valid.
REQ-012 rd_ready  in  1  operand memories accept the request.
REQ-013 act_addr  out  ADDR_W  activation read address.
REQ-014 w_addr  out  ADDR_W  weight read address.
REQ-015 mac_clear  out  1  clears the datapath accumulator.
REQ-016 mac_last  out  1  marks the final k-term of the current dot product; qualified by rd_valid&rd_ready.
REQ-017 wr_valid  out  1  result write request valid.
REQ-018 wr_ready  in  1  result memory accepts the write.
REQ-019 wr_addr  out  ADDR_W  result write address.

Function
REQ-020 FSM states: IDLE, CLR, READ, DRAIN, WRITE, DONE.
REQ-021 IDLE: when proj_start=1, go to CLR with r=c=k=0; otherwise stay in IDLE.
REQ-022 proj_start is sampled only in IDLE; deassertion mid-job is ignored and the job runs to completion.
REQ-023 CLR: mac_clear=1 for exactly one cycle, then go to READ.
REQ-024 READ: rd_valid=1; act_addr = r*D_MODEL+k; w_addr = job_sel*D_MODEL*D_MODEL + k*D_MODEL + c.
REQ-025 In READ, k increments on each rd_valid&rd_ready.
REQ-026 In READ, mac_last=1 when k==D_MODEL-1; the handshake on that term moves the FSM to DRAIN.
REQ-027 When rd_ready=0, rd_valid, act_addr, w_addr and mac_last hold stable.
REQ-028 DRAIN: a counter waits exactly MAC_LAT cycles, then the FSM goes to WRITE.
REQ-029 WRITE: wr_valid=1; wr_addr = job_sel*SEQ_LEN*D_MODEL + r*D_MODEL + c; wr_valid and wr_addr hold until wr_ready=1.
REQ-030 Output order after an accepted write: c increments first. At c==D_MODEL-1, c wraps to 0 and r increments. After the last output (r==SEQ_LEN-1, c==D_MODEL-1) go to DONE; otherwise go to CLR with k=0.
REQ-031 DONE: proj_done=1 for exactly one cycle; job_sel increments modulo 4 (3 wraps to 0); then go to IDLE.
REQ-032 At least one IDLE cycle follows every DONE. If proj_start is still high in that IDLE cycle, the next job starts (back-to-back Q, K, V).
REQ-033 With rd_ready=wr_ready=1, each output takes 1+D_MODEL+MAC_LAT+1 cycles; the job takes SEQ_LEN*D_MODEL times that, plus the DONE cycle.
REQ-034 All addresses are computed unsigned and truncated to ADDR_W.
REQ-035 rd_valid, wr_valid, mac_clear and proj_done are mutually exclusive and are never asserted in IDLE.

Reset
REQ-036 On rstn=0, immediately and at any point in a job, the block returns to IDLE.
REQ-037 Reset values: job_sel=0, act_sel=0, all counters 0, every output low and every address 0.
REQ-038 After reset release, the first job is Q; an interrupted job is not resumed.

Verification
REQ-039 SEQ_LEN=2, D_MODEL=2, MAC_LAT=3, ready inputs tied 1, proj_start held 1 -> mac_clear seen first; proj_done pulses exactly 28 cycles later. Expected wr_addr sequence 0,1,2,3 and w_addr sequence 0,2,1,3,0,2,1,3.
REQ-040 Same setup, proj_start held high through 4 jobs -> 4 done pulses, each separated by one IDLE cycle. job_sel goes 0,1,2,3 then returns to 0. act_sel=1 only during the 4th job, whose wr_addr range is 12..15.
REQ-041 rd_ready=0 for 5 cycles mid-READ -> rd_valid, act_addr and w_addr stay constant; total job time grows by 5 cycles.
REQ-042 wr_ready=0 for 3 cycles in WRITE -> wr_valid/wr_addr hold; the write completes once wr_ready=1, with no duplicate or skipped addresses.
REQ-043 proj_start dropped 2 cycles after job start -> the job completes and proj_done pulses once; no new job starts while proj_start=0.
REQ-044 rstn pulsed low during DRAIN of job 1 (K) -> all outputs 0 immediately; the next job after release uses job_sel=0.
